// File: rtl/oric_kbd_matrix_gen.sv
// Oric keyboard matrix generator: PS/2 events and a timed key-injection queue
// are merged into the active-low row sense for the column the VIA is scanning.
module oric_kbd_matrix_gen #(
    parameter int unsigned COLS       = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned CW         = $clog2(COLS),
    parameter int unsigned RW         = $clog2(ROWS),
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned HOLD_CYC   = 480000,
    parameter int unsigned GAP_CYC    = 480000,
    parameter int unsigned SHIFT_COL  = 4,
    parameter int unsigned SHIFT_ROW  = 4,
    parameter logic [8:0]  BRK_CODE   = 9'h009
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    output logic [8:0]       map_addr,
    input  logic [CW+RW:0]   map_data,
    input  logic [CW-1:0]    col,
    output logic [ROWS-1:0]  ROWbit,
    input  logic [CW+RW:0]   inj_data,
    input  logic             inj_valid,
    output logic             inj_ready,
    input  logic             inj_flush,
    output logic             inj_busy,
    output logic             swrst
);

    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CNTW-1:0] HOLD_LOAD = CNTW'(HOLD_CYC - 1);
    localparam logic [CNTW-1:0] GAP_LOAD  = CNTW'(GAP_CYC - 1);
    localparam logic [CW-1:0]   SH_COL    = CW'(SHIFT_COL);
    localparam logic [RW-1:0]   SH_ROW    = RW'(SHIFT_ROW);

    typedef enum logic [1:0] {StIdle, StPress, StGap} seq_e;

    // PS/2 event detection and lookup pipeline
    logic                      tog_q;
    logic                      lk_valid_q;
    logic                      pressed_q;
    logic                      ev;
    logic                      map_valid;
    logic [CW-1:0]             map_col;
    logic [RW-1:0]             map_row;
    logic [COLS-1:0][ROWS-1:0] key_state;

    // Injection queue and sequencer
    logic [CW+RW:0]            mem [FIFO_DEPTH];
    logic [AW:0]               wptr_q;
    logic [AW:0]               rptr_q;
    logic                      empty;
    logic                      full;
    logic                      push;
    logic                      head_shift;
    logic [CW-1:0]             head_col;
    logic [RW-1:0]             head_row;
    logic [COLS-1:0][ROWS-1:0] head_mask;
    logic [COLS-1:0][ROWS-1:0] inj_state;
    seq_e                      st_q;
    logic [CNTW-1:0]           cnt_q;

    logic [COLS-1:0][ROWS-1:0] eff;
    logic                      col_ok;
    logic                      map_col_ok;
    logic                      head_col_ok;
    logic                      map_row_ok;
    logic                      head_row_ok;

    // Range checks collapse to constants when the index width covers the matrix exactly.
    if (COLS == (1 << CW)) begin : g_col_full
        assign col_ok      = 1'b1;
        assign map_col_ok  = 1'b1;
        assign head_col_ok = 1'b1;
    end else begin : g_col_part
        assign col_ok      = 32'(col) < COLS;
        assign map_col_ok  = 32'(map_col) < COLS;
        assign head_col_ok = 32'(head_col) < COLS;
    end

    if (ROWS == (1 << RW)) begin : g_row_full
        assign map_row_ok  = 1'b1;
        assign head_row_ok = 1'b1;
    end else begin : g_row_part
        assign map_row_ok  = 32'(map_row) < ROWS;
        assign head_row_ok = 32'(head_row) < ROWS;
    end

    assign ev = ps2_key[10] ^ tog_q;
    assign {map_valid, map_col, map_row} = map_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q      <= ps2_key[10];
            lk_valid_q <= 1'b0;
            pressed_q  <= 1'b0;
            map_addr   <= '0;
            swrst      <= 1'b0;
            key_state  <= '0;
        end else begin
            tog_q      <= ps2_key[10];
            lk_valid_q <= ev;
            if (ev) begin
                map_addr  <= ps2_key[8:0];
                pressed_q <= ps2_key[9];
                if (ps2_key[8:0] == BRK_CODE) begin
                    swrst <= ps2_key[9];
                end
            end
            if (lk_valid_q && map_valid && map_col_ok && map_row_ok) begin
                key_state[map_col][map_row] <= pressed_q;
            end
        end
    end

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign inj_ready = !full;
    assign push      = inj_valid && !full && !inj_flush;
    assign inj_busy  = !empty || (st_q != StIdle);

    assign {head_shift, head_col, head_row} = mem[rptr_q[AW-1:0]];

    always_comb begin
        head_mask = '0;
        if (head_col_ok && head_row_ok) begin
            head_mask[head_col][head_row] = 1'b1;
        end
        if (head_shift) begin
            head_mask[SH_COL][SH_ROW] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= inj_data;
        end
    end

    // Flush shares the reset path: a write in the same cycle is dropped via push.
    always_ff @(posedge clk) begin
        if (reset || inj_flush) begin
            st_q      <= StIdle;
            cnt_q     <= '0;
            inj_state <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            unique case (st_q)
                StIdle: begin
                    if (!empty) begin
                        rptr_q    <= rptr_q + 1'b1;
                        inj_state <= head_mask;
                        cnt_q     <= HOLD_LOAD;
                        st_q      <= StPress;
                    end
                end
                StPress: begin
                    if (cnt_q == '0) begin
                        inj_state <= '0;
                        cnt_q     <= GAP_LOAD;
                        st_q      <= StGap;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        st_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign eff = key_state | inj_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            ROWbit <= '1;
        end else if (col_ok) begin
            ROWbit <= ~eff[col];
        end else begin
            ROWbit <= '1;
        end
    end

endmodule

// File: tb/tb_oric_kbd_matrix_gen.sv
// Bench for oric_kbd_matrix_gen: a time-scheduled reference model checked every
// cycle, plus directed scenarios with literal expectations and a random phase.
module tb_oric_kbd_matrix_gen;

    localparam int COLS  = 8;
    localparam int ROWS  = 8;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 3;
    localparam int SHC   = 4;
    localparam int SHR   = 4;
    localparam logic [8:0] BRK = 9'h009;

    typedef logic [7:0][7:0] mat_t;
    typedef struct {
        int         t;
        logic [8:0] code;
        logic       p;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [8:0]  map_addr;
    logic [6:0]  map_data;
    logic [2:0]  col;
    logic [7:0]  ROWbit;
    logic [6:0]  inj_data;
    logic        inj_valid;
    logic        inj_ready;
    logic        inj_flush;
    logic        inj_busy;
    logic        swrst;

    logic [6:0]  rom [512];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         cyc = 0;
    bit         chk_en = 1'b0;
    mat_t       key_m;
    mat_t       eff;
    logic [7:0] exp_rowbit;
    logic       exp_swrst;
    logic [8:0] exp_map_addr;
    logic       exp_ready;
    logic       exp_busy;
    ev_t        evq[$];
    logic [6:0] q[$];
    logic [6:0] ent;
    logic [6:0] act_data;
    bit         act_on = 1'b0;
    int         act_from;
    int         act_to;
    int         next_pop = 0;
    int         size_prev;

    always #5 clk = ~clk;

    assign map_data = rom[map_addr];

    oric_kbd_matrix_gen #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .FIFO_DEPTH(DEPTH),
        .HOLD_CYC  (HOLD),
        .GAP_CYC   (GAP),
        .SHIFT_COL (SHC),
        .SHIFT_ROW (SHR),
        .BRK_CODE  (BRK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .map_addr (map_addr),
        .map_data (map_data),
        .col      (col),
        .ROWbit   (ROWbit),
        .inj_data (inj_data),
        .inj_valid(inj_valid),
        .inj_ready(inj_ready),
        .inj_flush(inj_flush),
        .inj_busy (inj_busy),
        .swrst    (swrst)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Injected keys visible in cycle m.
    function automatic mat_t inj_at(input int m);
        mat_t mk = '0;
        if (act_on && m >= act_from && m <= act_to) begin
            mk[act_data[5:3]][act_data[2:0]] = 1'b1;
            if (act_data[6]) mk[SHC][SHR] = 1'b1;
        end
        return mk;
    endfunction

    // Cycle n is the interval after rising edge n.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            chk_en       = 1'b1;
            key_m        = '0;
            exp_swrst    = 1'b0;
            exp_map_addr = '0;
            exp_rowbit   = '1;
            evq.delete();
            q.delete();
            act_on   = 1'b0;
            next_pop = 0;
        end else begin
            eff        = key_m | inj_at(cyc - 1);
            exp_rowbit = ~eff[col];
            foreach (evq[i]) begin
                if (evq[i].t + 1 == cyc) begin
                    exp_map_addr = evq[i].code;
                    if (evq[i].code == BRK) exp_swrst = evq[i].p;
                end
                if (evq[i].t + 2 == cyc) begin
                    ent = rom[evq[i].code];
                    if (ent[6]) key_m[ent[5:3]][ent[2:0]] = evq[i].p;
                end
            end
            while (evq.size() > 0 && evq[0].t + 2 <= cyc) void'(evq.pop_front());

            size_prev = q.size();
            if (inj_flush) begin
                q.delete();
                if (act_on && act_to >= cyc) act_to = cyc - 1;
                next_pop = cyc + 1;
            end else begin
                if (q.size() > 0 && cyc >= next_pop) begin
                    act_data = q.pop_front();
                    act_on   = 1'b1;
                    act_from = cyc;
                    act_to   = cyc + HOLD - 1;
                    next_pop = cyc + HOLD + GAP + 1;
                end
                if (inj_valid && size_prev < DEPTH) q.push_back(inj_data);
            end
        end
        exp_ready = (q.size() < DEPTH);
        exp_busy  = (q.size() > 0) || (cyc < next_pop - 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ROWbit", 32'(ROWbit), 32'(exp_rowbit));
            check("swrst", 32'(swrst), 32'(exp_swrst));
            check("map_addr", 32'(map_addr), 32'(exp_map_addr));
            check("inj_ready", 32'(inj_ready), 32'(exp_ready));
            check("inj_busy", 32'(inj_busy), 32'(exp_busy));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ps2_event(input logic [8:0] code, input logic pr);
        ps2_key = {~ps2_key[10], pr, code};
        evq.push_back('{cyc, code, pr});
    endtask

    task automatic inj_push(input logic [6:0] d);
        inj_data  = d;
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
    endtask

    int lowcnt;

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 7'($urandom);
        rom[9'h01C] = 7'b1_110_101;
        rom[9'h01B] = 7'b1_110_110;
        rom[BRK]    = 7'b0_000_000;

        reset     = 1'b1;
        ps2_key   = 11'h400;
        col       = 3'd0;
        inj_data  = '0;
        inj_valid = 1'b0;
        inj_flush = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_rowbit", 32'(ROWbit), 32'hFF);
        check("reset_ready", 32'(inj_ready), 32'd1);
        check("reset_busy", 32'(inj_busy), 32'd0);

        // Single key press and release
        col = 3'd6;
        ps2_event(9'h01C, 1'b1);
        repeat (4) tick();
        check("press_a", 32'(ROWbit), 32'hDF);
        ps2_event(9'h01C, 1'b0);
        repeat (4) tick();
        check("release_a", 32'(ROWbit), 32'hFF);

        // Back-to-back events
        ps2_event(9'h01C, 1'b1);
        tick();
        ps2_event(9'h01B, 1'b1);
        repeat (4) tick();
        check("press_a_s", 32'(ROWbit), 32'h9F);
        ps2_event(9'h01C, 1'b0);
        tick();
        ps2_event(9'h01B, 1'b0);
        repeat (4) tick();
        check("release_a_s", 32'(ROWbit), 32'hFF);

        // Break key
        ps2_event(BRK, 1'b1);
        tick();
        check("swrst_on", 32'(swrst), 32'd1);
        repeat (3) tick();
        check("brk_rowbit", 32'(ROWbit), 32'hFF);
        ps2_event(BRK, 1'b0);
        tick();
        check("swrst_off", 32'(swrst), 32'd0);
        repeat (2) tick();

        // Injection with shift
        col = 3'd2;
        inj_push(7'b1_010_000);
        lowcnt = 0;
        repeat (12) begin
            tick();
            if (ROWbit == 8'hFE) lowcnt++;
        end
        check("inj_hold_len", 32'(lowcnt), 32'd4);
        check("inj_busy_fall", 32'(inj_busy), 32'd0);
        col = 3'd4;
        inj_push(7'b1_010_000);
        lowcnt = 0;
        repeat (12) begin
            tick();
            if (ROWbit == 8'hEF) lowcnt++;
        end
        check("inj_shift_len", 32'(lowcnt), 32'd4);

        // Fill then flush with a simultaneous write
        col       = 3'd2;
        inj_data  = 7'b0_010_000;
        inj_valid = 1'b1;
        for (int i = 0; i < 20 && inj_ready; i++) tick();
        check("fifo_full", 32'(inj_ready), 32'd0);
        inj_flush = 1'b1;
        tick();
        inj_flush = 1'b0;
        inj_valid = 1'b0;
        check("flush_ready", 32'(inj_ready), 32'd1);
        check("flush_busy", 32'(inj_busy), 32'd0);
        tick();
        check("flush_rowbit", 32'(ROWbit), 32'hFF);
        repeat (2) tick();

        // Reset while a key is held and an injection is pressing
        col = 3'd6;
        ps2_event(9'h01C, 1'b1);
        inj_push(7'b0_110_110);
        repeat (3) tick();
        check("pre_reset_rowbit", 32'(ROWbit), 32'h9F);
        reset = 1'b1;
        tick();
        check("rst_rowbit", 32'(ROWbit), 32'hFF);
        check("rst_busy", 32'(inj_busy), 32'd0);
        check("rst_map_addr", 32'(map_addr), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("post_reset_rowbit", 32'(ROWbit), 32'hFF);

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            col = 3'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 7) == 0) ps2_event(BRK, 1'($urandom));
                else ps2_event(9'($urandom_range(0, 511)), 1'($urandom));
            end
            inj_valid = ($urandom_range(0, 5) == 0);
            inj_data  = 7'($urandom);
            inj_flush = ($urandom_range(0, 79) == 0);
            tick();
        end
        inj_valid = 1'b0;
        inj_flush = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oric_kbd_matrix_gen.md
ORIC_KBD_MATRIX_GEN -- requirements
Module: oric_kbd_matrix_gen

Interface
REQ-001 Parameter COLS, default 8, number of matrix columns.
REQ-002 Parameter ROWS, default 8, number of matrix rows; ROWbit width.
REQ-003 Parameter CW, default $clog2(COLS); RW, default $clog2(ROWS).
REQ-004 Parameter FIFO_DEPTH, default 16, inject queue entries, power of two.
REQ-005 Parameter HOLD_CYC, default 480000, clk cycles an injected key is held.
REQ-006 Parameter GAP_CYC, default 480000, clk cycles of release gap after each injected key.
REQ-007 Parameters SHIFT_COL, default 4, and SHIFT_ROW, default 4, give the matrix position of left shift.
REQ-008 Parameter BRK_CODE, default 9'h009, the PS/2 code that drives swrst (F10).
REQ-009 The block has one clock; reset is synchronous and active-high.
REQ-010 clk  in  1  sole clock; all state updates on its rising edge.
REQ-011 reset  in  1  synchronous, active-high.
REQ-012 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-013 map_addr  out  9  scancode lookup address {extended, code}, registered.
REQ-014 map_data  in  1+CW+RW  {valid, col, row}, valid one cycle after map_addr.
REQ-015 col  in  CW  column currently scanned by the VIA.
REQ-016 ROWbit  out  ROWS  active-low row sense for col, registered.
REQ-017 inj_data  in  1+CW+RW  {shift, col, row} for an injected key.
REQ-018 inj_valid  in  1  / inj_ready  out  1  valid/ready handshake into the inject FIFO.
REQ-019 inj_flush  in  1  discard the queue and abort the current injected key.
REQ-020 inj_busy  out  1  high when the FIFO is non-empty or the sequencer is not IDLE.
REQ-021 swrst  out  1  level, high while BRK_CODE is held.

Function
REQ-022 An event is a cycle T in which ps2_key[10] differs from its value registered at T-1.
REQ-023 At the T+1 edge, the block shall load map_addr with ps2_key[8:0] and register pressed; at the T+2 edge, if map_data.valid, it shall set key_state[col][row] to pressed.
REQ-024 The lookup is pipelined and accepts one event per cycle with no event lost.
REQ-025 map_data.valid=0 shall leave key_state unchanged; a col >= COLS in map_data shall be ignored.
REQ-026 An event with code==BRK_CODE shall set swrst to pressed at the T+1 edge, independent of map_data.
REQ-027 The effective matrix is key_state OR inj_state; multiple keys per column combine, with no ghost suppression.
REQ-028 ROWbit shall equal ~(effective column col) registered, 1 cycle latency; col >= COLS shall give all ones.
REQ-029 inj_ready = FIFO not full; an entry is written when inj_valid and inj_ready are both high.
REQ-030 Sequencer states: IDLE, PRESS, GAP.
REQ-031 IDLE->PRESS when the FIFO is non-empty: pop the entry, set inj_state for (col,row), also set (SHIFT_COL,SHIFT_ROW) if shift, load counter with HOLD_CYC-1.
REQ-032 PRESS->GAP when the counter reaches 0: clear inj_state, load counter with GAP_CYC-1.
REQ-033 GAP->IDLE when the counter reaches 0; back-to-back entries shall be spaced exactly HOLD_CYC+GAP_CYC+1 cycles.
REQ-034 inj_flush shall empty the FIFO, clear inj_state and go to IDLE at the next edge; flush has priority over a simultaneous write, which is dropped.
REQ-035 Simultaneous FIFO push and pop when full: pop proceeds, push is refused because inj_ready=0.
REQ-036 PS/2 events and injection are independent; a physical release never clears an injected key, and vice versa.

Reset
REQ-037 On reset: key_state=0, inj_state=0, FIFO empty, sequencer IDLE, counter=0, map_addr=0, swrst=0, ROWbit all ones, inj_ready=1, inj_busy=0, registered toggle captures ps2_key[10] (no spurious event).
REQ-038 Reset mid-injection or mid-lookup shall discard all in-flight work.

Verification
REQ-039 Press 'a': toggle with code 9'h01C, map returns {1,6,5}, col=6 -> ROWbit=8'b11011111 by T+4; release -> 8'hFF.
REQ-040 Two events on consecutive cycles (a, s = {1,6,6}) -> ROWbit=8'b10011111 with col=6; neither lost.
REQ-041 F10 press/release (9'h009, map valid=0) -> swrst 1 then 0; ROWbit stays 8'hFF.
REQ-042 HOLD_CYC=4, GAP_CYC=3: push {1,2,0} -> col=2 gives ROWbit 8'b11111110 for 4 cycles, col=4 gives 8'b11101111, then 3 cycles of 8'hFF, inj_busy falls.
REQ-043 Fill FIFO_DEPTH entries -> inj_ready=0; inj_flush -> inj_ready=1, inj_busy=0, inj_state=0 next cycle.
REQ-044 Assert reset while a key is held and an injection is in PRESS -> all outputs at reset values next cycle.
